// File: rtl/clock_pkg.sv
// Shared types, field limits and BCD/12-hour helpers for the digital clock core.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN         = 3'd0,
    ST_SET_HOURS   = 3'd1,
    ST_SET_MINUTES = 3'd2,
    ST_SET_SECONDS = 3'd3,
    ST_ALM_HOURS   = 3'd4,
    ST_ALM_MINUTES = 3'd5
  } state_t;

  typedef struct packed {
    logic       en;
    logic [3:0] value;
    logic       dp;
  } digit_t;

  localparam int HOURS_MAX   = 23;
  localparam int MIN_SEC_MAX = 59;

  // Split a 0-59 binary field into {tens, units} BCD digits.
  function automatic logic [7:0] bin2bcd(input logic [5:0] bin);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'(bin / 6'd10);
    rem  = bin - ({2'b00, tens} * 6'd10);
    return {tens, 4'(rem)};
  endfunction

  // Map stored 0-23 hours onto the 1-12 clock face.
  function automatic logic [4:0] hour12(input logic [4:0] h24);
    logic [4:0] h;
    h = (h24 >= 5'd12) ? (h24 - 5'd12) : h24;
    return (h == 5'd0) ? 5'd12 : h;
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo up/down field counter; wrap flags an upward step out of MAX so the
// next field can be carried into.
module mod_updown_counter #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             carry_in,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_value;
  logic             w_up;

  assign w_up  = inc | carry_in;
  assign wrap  = w_up & ~dec & (r_value == MAX_V);
  assign value = r_value;

  // Opposing up and down requests cancel out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= '0;
    end else if (w_up && !dec) begin
      r_value <= (r_value == MAX_V) ? '0 : (r_value + ONE_V);
    end else if (dec && !w_up) begin
      r_value <= (r_value == '0) ? MAX_V : (r_value - ONE_V);
    end else begin
      r_value <= r_value;
    end
  end

endmodule

// File: rtl/clock_core_param.sv
// hh:mm:ss clock core with mode/set FSM, field blinking, optional alarm with
// snooze and add/sub auto-repeat; drives an 8-digit registered display.
module clock_core_param
  import clock_pkg::*;
#(
  parameter bit          H24          = 1'b1,
  parameter bit          ALARM_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_1hz,
  input  logic       pulse_500ms,
  input  logic       mode_button,
  input  logic       add_button,
  input  logic       sub_button,
  input  logic       alarm_arm,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic       alarm_ring,
  output logic [2:0] state
);

  localparam logic [3:0] REP_LIMIT = 4'(REPEAT_DELAY);

  state_t     r_state, w_state_nxt;
  logic       r_mode_q, r_add_q, r_sub_q;
  logic       w_mode_p, w_add_p, w_sub_p;
  logic       w_edit, w_hold_alone, w_repeat, w_up, w_dn, w_step, w_tick;
  logic [3:0] r_hold;
  logic       r_blink, r_snooze, w_snooze_nxt, w_match, r_alarm_ring;
  logic [4:0] w_hours, w_alm_hours, w_hr_view;
  logic [5:0] w_minutes, w_seconds, w_alm_minutes, w_mn_view;
  logic       w_sec_wrap, w_min_wrap;
  logic       w_unused_hrs_wrap;
  logic [7:0] w_hr_bcd, w_mn_bcd, w_sc_bcd;
  logic       w_alm_view, w_hr_vis, w_mn_vis, w_sc_vis, w_colon;
  digit_t     w_dig [1:8];
  digit_t     r_dig [1:8];

  assign w_mode_p     = mode_button & ~r_mode_q;
  assign w_add_p      = add_button & ~r_add_q;
  assign w_sub_p      = sub_button & ~r_sub_q;
  assign w_edit       = (r_state != ST_RUN);
  assign w_hold_alone = w_edit & (add_button ^ sub_button);
  assign w_repeat     = w_hold_alone & pulse_500ms & (r_hold == REP_LIMIT);
  // A mode press swallows any add/sub activity in the same cycle.
  assign w_up   = w_edit & ~w_mode_p & ((w_add_p & ~w_sub_p) | (w_repeat & add_button));
  assign w_dn   = w_edit & ~w_mode_p & ((w_sub_p & ~w_add_p) | (w_repeat & sub_button));
  assign w_step = w_up | w_dn;
  assign w_tick = ~w_edit & pulse_1hz;

  mod_updown_counter #(.MAX(MIN_SEC_MAX), .WIDTH(6)) u_seconds (
    .clock(clock), .reset(reset),
    .inc(w_up & (r_state == ST_SET_SECONDS)), .dec(w_dn & (r_state == ST_SET_SECONDS)),
    .carry_in(w_tick), .value(w_seconds), .wrap(w_sec_wrap)
  );
  mod_updown_counter #(.MAX(MIN_SEC_MAX), .WIDTH(6)) u_minutes (
    .clock(clock), .reset(reset),
    .inc(w_up & (r_state == ST_SET_MINUTES)), .dec(w_dn & (r_state == ST_SET_MINUTES)),
    .carry_in(w_sec_wrap & w_tick), .value(w_minutes), .wrap(w_min_wrap)
  );
  mod_updown_counter #(.MAX(HOURS_MAX), .WIDTH(5)) u_hours (
    .clock(clock), .reset(reset),
    .inc(w_up & (r_state == ST_SET_HOURS)), .dec(w_dn & (r_state == ST_SET_HOURS)),
    .carry_in(w_min_wrap & w_tick), .value(w_hours), .wrap(w_unused_hrs_wrap)
  );

  generate
    if (ALARM_EN) begin : g_alarm
      logic w_unused_alm_h_wrap, w_unused_alm_m_wrap;
      mod_updown_counter #(.MAX(HOURS_MAX), .WIDTH(5)) u_alm_hours (
        .clock(clock), .reset(reset),
        .inc(w_up & (r_state == ST_ALM_HOURS)), .dec(w_dn & (r_state == ST_ALM_HOURS)),
        .carry_in(1'b0), .value(w_alm_hours), .wrap(w_unused_alm_h_wrap)
      );
      mod_updown_counter #(.MAX(MIN_SEC_MAX), .WIDTH(6)) u_alm_minutes (
        .clock(clock), .reset(reset),
        .inc(w_up & (r_state == ST_ALM_MINUTES)), .dec(w_dn & (r_state == ST_ALM_MINUTES)),
        .carry_in(1'b0), .value(w_alm_minutes), .wrap(w_unused_alm_m_wrap)
      );
    end else begin : g_no_alarm
      assign w_alm_hours   = 5'd0;
      assign w_alm_minutes = 6'd0;
    end
  endgenerate

  // Mode-press sequencing; alarm states are skipped when the alarm is absent.
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_p) begin
      case (r_state)
        ST_RUN:         w_state_nxt = ST_SET_HOURS;
        ST_SET_HOURS:   w_state_nxt = ST_SET_MINUTES;
        ST_SET_MINUTES: w_state_nxt = ST_SET_SECONDS;
        ST_SET_SECONDS: w_state_nxt = ALARM_EN ? ST_ALM_HOURS : ST_RUN;
        ST_ALM_HOURS:   w_state_nxt = ST_ALM_MINUTES;
        ST_ALM_MINUTES: w_state_nxt = ST_RUN;
        default:        w_state_nxt = ST_RUN;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_match = (r_state == ST_RUN) && (w_hours == w_alm_hours) &&
                   (w_minutes == w_alm_minutes);

  // Snooze latches on an add/sub press while ringing and lasts until the minute moves on.
  always_comb begin
    w_snooze_nxt = r_snooze;
    if (!w_match) begin
      w_snooze_nxt = 1'b0;
    end else if (r_alarm_ring && !w_mode_p && (w_add_p || w_sub_p)) begin
      w_snooze_nxt = 1'b1;
    end else begin
      w_snooze_nxt = r_snooze;
    end
  end

  // Display composition: alarm fields replace time in the ALM states.
  always_comb begin
    w_alm_view = (r_state == ST_ALM_HOURS) || (r_state == ST_ALM_MINUTES);
    w_hr_view  = w_alm_view ? w_alm_hours : w_hours;
    w_mn_view  = w_alm_view ? w_alm_minutes : w_minutes;
    if (H24) begin
      w_hr_bcd = bin2bcd({1'b0, w_hr_view});
    end else begin
      w_hr_bcd = bin2bcd({1'b0, hour12(w_hr_view)});
    end
    w_mn_bcd = bin2bcd(w_mn_view);
    w_sc_bcd = bin2bcd(w_seconds);
    w_hr_vis = ~(r_blink & ((r_state == ST_SET_HOURS) || (r_state == ST_ALM_HOURS)));
    w_mn_vis = ~(r_blink & ((r_state == ST_SET_MINUTES) || (r_state == ST_ALM_MINUTES)));
    w_sc_vis = ~w_alm_view & ~(r_blink & (r_state == ST_SET_SECONDS));
    w_colon  = (r_state == ST_RUN) ? ~r_blink : 1'b1;
    w_dig[8] = {w_hr_vis & (H24 | (w_hr_bcd[7:4] != 4'd0)), w_hr_bcd[7:4], 1'b0};
    w_dig[7] = {w_hr_vis, w_hr_bcd[3:0], ~H24 & (w_hr_view >= 5'd12)};
    w_dig[6] = {1'b0, 4'h0, w_colon};
    w_dig[5] = {w_mn_vis, w_mn_bcd[7:4], 1'b0};
    w_dig[4] = {w_mn_vis, w_mn_bcd[3:0], 1'b0};
    w_dig[3] = {1'b0, 4'h0, w_colon};
    w_dig[2] = {w_sc_vis, w_sc_bcd[7:4], 1'b0};
    w_dig[1] = {w_sc_vis, w_sc_bcd[3:0], 1'b0};
  end

  // Control state, button history, repeat timer, blink, alarm and display registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_mode_q     <= 1'b0;
      r_add_q      <= 1'b0;
      r_sub_q      <= 1'b0;
      r_hold       <= 4'd0;
      r_blink      <= 1'b0;
      r_snooze     <= 1'b0;
      r_alarm_ring <= 1'b0;
      r_dig        <= '{default: '0};
    end else begin
      r_state  <= w_state_nxt;
      r_mode_q <= mode_button;
      r_add_q  <= add_button;
      r_sub_q  <= sub_button;
      if (!w_hold_alone || w_mode_p) begin
        r_hold <= 4'd0;
      end else if (pulse_500ms && (r_hold != REP_LIMIT)) begin
        r_hold <= r_hold + 4'd1;
      end
      // Stepping pins the edited field visible so it can be read while adjusting.
      if (w_step) begin
        r_blink <= 1'b0;
      end else if (pulse_500ms) begin
        r_blink <= ~r_blink;
      end
      r_snooze     <= w_snooze_nxt;
      r_alarm_ring <= ALARM_EN & alarm_arm & w_match & ~w_snooze_nxt;
      r_dig        <= w_dig;
    end
  end

  assign d1         = r_dig[1];
  assign d2         = r_dig[2];
  assign d3         = r_dig[3];
  assign d4         = r_dig[4];
  assign d5         = r_dig[5];
  assign d6         = r_dig[6];
  assign d7         = r_dig[7];
  assign d8         = r_dig[8];
  assign alarm_ring = r_alarm_ring;
  assign state      = r_state;

endmodule
